// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Shares one PicoRV32-native slave bus between two masters: the CPU (m0)
// and a second bus master such as a DMA/LCD fill engine (m1). Sits in
// front of the address decoder and slave mux.
//
//   - Round-robin grant: on a tie, the master not served last wins.
//   - The grant is held for exactly one transaction.
//   - The bus always returns to ARB for at least one cycle between
//     transactions, so a slave that holds ready high as a level never
//     completes two transactions back to back.
//   - A watchdog ends a transaction that has seen no s_ready for
//     TIMEOUT_CYCLES BUSY cycles. The owner gets ready with ERR_DATA and
//     any pending write is dropped.
//
// Parameters
//   TIMEOUT_CYCLES  BUSY cycles before forced termination (0 = off, max 65535)
//   ERR_DATA        rdata returned to the owner on a timeout
//
// Ports
//   clk                  system clock, rising edge
//   reset_n              synchronous active-low reset
//   m0_*/m1_*            master request side: valid/addr/wdata/wstrb in,
//                        ready/rdata out (wstrb == 0 means read)
//   s_valid/addr/wdata/wstrb  request forwarded to the decoder/slaves
//   s_ready/s_rdata      slave completion and read data
//   grant                one-hot owner while BUSY, 0 in ARB
//   timeout              one-cycle pulse on a watchdog termination
//   err_count            saturating count of watchdog terminations
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout,
    output logic [7:0]  err_count
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // The watchdog fires on the TIMEOUT_CYCLES-th BUSY cycle. The counter
    // reads 0 on the first BUSY cycle, so the threshold is TIMEOUT_CYCLES-1.
    localparam logic        WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WD_LAST = WD_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic        owner_q,     owner_d;      // 0 = m0, 1 = m1
    logic        last_q,      last_d;       // master served by the last completion
    logic [15:0] wd_cnt_q,    wd_cnt_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [1:0]  grant_q,     grant_d;
    logic        s_valid_q,   s_valid_d;

    // ------------------------------------------------------------------
    // Current-cycle decode
    // ------------------------------------------------------------------
    logic        busy;
    logic        owner_valid;
    logic        wd_fire;
    logic        done;
    logic [31:0] rsp_data;

    assign busy        = (state_q == ST_BUSY);
    assign owner_valid = owner_q ? m1_valid : m0_valid;

    // A real s_ready on the threshold cycle wins: it is a normal
    // completion and no timeout is reported. An owner that has already
    // dropped valid gets neither kind of completion.
    assign wd_fire  = WD_EN && busy && owner_valid && !s_ready && (wd_cnt_q == WD_LAST);
    assign done     = busy && owner_valid && (s_ready || wd_fire);
    assign rsp_data = wd_fire ? ERR_DATA : s_rdata;

    // ------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------
    // Responses go straight from the slave to the owner with no register
    // in the path. The non-owner always sees zeros.
    assign m0_ready = done && !owner_q;
    assign m1_ready = done &&  owner_q;
    assign m0_rdata = (busy && !owner_q) ? rsp_data : 32'd0;
    assign m1_rdata = (busy &&  owner_q) ? rsp_data : 32'd0;
    assign timeout  = wd_fire;

    // The request is forwarded from the owner's live inputs. Only the
    // select (owner_q) is registered. The bus reads as zero in ARB.
    assign s_addr  = busy ? (owner_q ? m1_addr  : m0_addr)  : 32'd0;
    assign s_wdata = busy ? (owner_q ? m1_wdata : m0_wdata) : 32'd0;
    assign s_wstrb = busy ? (owner_q ? m1_wstrb : m0_wstrb) : 4'd0;

    // Registered outputs
    assign s_valid   = s_valid_q;
    assign grant     = grant_q;
    assign err_count = err_count_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        wd_cnt_d    = wd_cnt_q;
        err_count_d = err_count_q;

        unique case (state_q)
            ST_ARB: begin
                if (m0_valid || m1_valid) begin
                    state_d  = ST_BUSY;
                    wd_cnt_d = 16'd0;
                    if (m0_valid && m1_valid) begin
                        // Tie: the master that was not served last wins.
                        owner_d = ~last_q;
                    end else begin
                        owner_d = m1_valid;
                    end
                end
            end

            ST_BUSY: begin
                if (!owner_valid) begin
                    // The owner withdrew its request, for example because
                    // that master was reset. Release the bus without a
                    // completion and leave the round-robin history as it is.
                    state_d = ST_ARB;
                end else if (done) begin
                    state_d = ST_ARB;
                    last_d  = owner_q;
                    if (wd_fire && (err_count_q != 8'hFF)) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
            end

            default: state_d = ST_ARB;
        endcase

        // grant and s_valid are registered, so they are computed here
        // from the next state and owner.
        s_valid_d = (state_d == ST_BUSY);
        grant_d   = (state_d == ST_BUSY) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    end

    // ------------------------------------------------------------------
    // State registers (synchronous active-low reset)
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples its pre-edge value, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // last = 1 makes m0 the winner of the first tie.
            state_q     <= ST_ARB;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            wd_cnt_q    <= 16'd0;
            err_count_q <= 8'd0;
            grant_q     <= 2'b00;
            s_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            wd_cnt_q    <= wd_cnt_d;
            err_count_q <= err_count_d;
            grant_q     <= grant_d;
            s_valid_q   <= s_valid_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter with TIMEOUT_CYCLES = 8. A
// transaction-level reference model runs every cycle: it tracks whether the
// bus is taken, by whom, how many BUSY cycles the transaction has used, who
// was served last and how many timeouts have occurred. Directed scenarios
// check fixed expected values, and a randomized phase drives protocol-
// abiding masters and a slave with random wait states.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset_n;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr,  m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        timeout;
    logic [7:0]  err_count;

    bus_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .ERR_DATA      (ERR)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0_valid (m0_valid),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wstrb (m0_wstrb),
        .m0_ready (m0_ready),
        .m0_rdata (m0_rdata),
        .m1_valid (m1_valid),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wstrb (m1_wstrb),
        .m1_ready (m1_ready),
        .m1_rdata (m1_rdata),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .grant    (grant),
        .timeout  (timeout),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    bit mdl_known = 0;   // false until the first reset edge
    bit mdl_busy  = 0;   // a transaction currently owns the bus
    int mdl_owner = 0;   // 0 or 1
    int mdl_last  = 1;   // master served by the last completion
    int mdl_wait  = 0;   // BUSY cycles already spent in this transaction
    int mdl_err   = 0;

    bit exp_rdy [2];     // model's ready per master in the latest cycle

    // Observation tallies for the directed scenarios
    int          cnt_sv, cnt_r0, cnt_r1, cnt_to;
    logic [31:0] cap_rd0, cap_rd1, cap_addr, cap_wdata, arb_or;
    logic [3:0]  cap_wstrb;
    logic        obs_sv, prev_sv;
    logic [1:0]  obs_grant;
    logic [7:0]  obs_err;
    logic [1:0]  grant_log[$];

    task automatic clear_obs();
        cnt_sv = 0; cnt_r0 = 0; cnt_r1 = 0; cnt_to = 0;
        cap_rd0 = '0; cap_rd1 = '0; cap_addr = '0; cap_wdata = '0; cap_wstrb = '0;
        arb_or = '0;
        grant_log.delete();
    endtask

    // One clock cycle. The inputs are already driven. Outputs are checked
    // at the falling edge against the model, then the model advances at
    // the rising edge.
    task automatic step();
        logic [1:0]  mv;
        logic        rst_s, sr;
        bit          own_v, fire, done;
        logic        e_sv, e_to, e_r0, e_r1;
        logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
        logic [3:0]  e_wstrb;
        logic [1:0]  e_grant;

        @(negedge clk);
        mv    = {m1_valid, m0_valid};
        rst_s = reset_n;
        sr    = s_ready;

        e_sv = 0; e_to = 0; e_r0 = 0; e_r1 = 0;
        e_addr = '0; e_wdata = '0; e_wstrb = '0; e_rd0 = '0; e_rd1 = '0; e_grant = '0;
        own_v = 0; fire = 0; done = 0;
        if (mdl_busy) begin
            own_v   = mv[mdl_owner];
            fire    = own_v && !sr && (mdl_wait + 1 == TO);
            done    = own_v && (sr || fire);
            e_sv    = 1;
            e_to    = fire;
            e_grant = (mdl_owner == 0) ? 2'b01 : 2'b10;
            e_addr  = (mdl_owner == 0) ? m0_addr  : m1_addr;
            e_wdata = (mdl_owner == 0) ? m0_wdata : m1_wdata;
            e_wstrb = (mdl_owner == 0) ? m0_wstrb : m1_wstrb;
            if (mdl_owner == 0) begin
                e_r0 = done; e_rd0 = fire ? ERR : s_rdata;
            end else begin
                e_r1 = done; e_rd1 = fire ? ERR : s_rdata;
            end
        end
        exp_rdy[0] = e_r0;
        exp_rdy[1] = e_r1;

        if (mdl_known) begin
            check("s_valid",   32'(s_valid),   32'(e_sv));
            check("s_addr",    s_addr,         e_addr);
            check("s_wdata",   s_wdata,        e_wdata);
            check("s_wstrb",   32'(s_wstrb),   32'(e_wstrb));
            check("grant",     32'(grant),     32'(e_grant));
            check("m0_ready",  32'(m0_ready),  32'(e_r0));
            check("m1_ready",  32'(m1_ready),  32'(e_r1));
            check("m0_rdata",  m0_rdata,       e_rd0);
            check("m1_rdata",  m1_rdata,       e_rd1);
            check("timeout",   32'(timeout),   32'(e_to));
            check("err_count", 32'(err_count), 32'(mdl_err));
        end

        if (s_valid === 1'b1) begin
            cnt_sv++;
            cap_addr = s_addr; cap_wdata = s_wdata; cap_wstrb = s_wstrb;
            if (prev_sv !== 1'b1) grant_log.push_back(grant);
        end else begin
            arb_or = arb_or | s_addr | s_wdata | {28'd0, s_wstrb};
        end
        if (m0_ready === 1'b1) begin cnt_r0++; cap_rd0 = m0_rdata; end
        if (m1_ready === 1'b1) begin cnt_r1++; cap_rd1 = m1_rdata; end
        if (timeout === 1'b1) cnt_to++;
        prev_sv   = s_valid;
        obs_sv    = s_valid;
        obs_grant = grant;
        obs_err   = err_count;

        @(posedge clk);
        if (!rst_s) begin
            mdl_known = 1; mdl_busy = 0; mdl_last = 1; mdl_err = 0; mdl_wait = 0;
        end else if (mdl_known) begin
            if (!mdl_busy) begin
                if (mv != 2'b00) begin
                    mdl_busy  = 1;
                    mdl_wait  = 0;
                    mdl_owner = (mv == 2'b11) ? 1 - mdl_last : (mv[1] ? 1 : 0);
                end
            end else if (!own_v) begin
                mdl_busy = 0;
            end else if (done) begin
                mdl_busy = 0;
                mdl_last = mdl_owner;
                if (fire && mdl_err < 255) mdl_err++;
            end else begin
                mdl_wait++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    // Random master agents
    bit          req   [2];
    logic [31:0] r_addr[2], r_wdata[2];
    logic [3:0]  r_wstrb[2];

    initial begin
        logic [1:0] exp_seq [4];
        int         p;
        bit         seen;
        int         bc;

        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        reset_n = 1'b0;
        m0_valid = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready = 0; s_rdata = '0;
        prev_sv = 1'b0;
        clear_obs();

        // Reset state
        step();
        do_reset();
        step();
        check("reset_s_valid",   32'(obs_sv),    32'd0);
        check("reset_grant",     32'(obs_grant), 32'd0);
        check("reset_err_count", 32'(obs_err),   32'd0);

        // Single master read with two wait states
        clear_obs();
        m0_valid = 1; m0_addr = 32'h0002_0000; m0_wstrb = 4'h0;
        step();                               // ARB
        step(); step();                       // two wait states
        s_ready = 1; s_rdata = 32'h1234_5678;
        step();                               // completion
        m0_valid = 0; s_ready = 0; s_rdata = '0;
        step();
        check("single_sv_cycles", 32'(cnt_sv), 32'd3);
        check("single_m0_ready",  32'(cnt_r0), 32'd1);
        check("single_m0_rdata",  cap_rd0,     32'h1234_5678);
        check("single_m1_ready",  32'(cnt_r1), 32'd0);
        check("single_grant",     32'(grant_log.size() > 0 ? grant_log[0] : 2'b00), 32'(2'b01));

        // Contention right after reset, both masters keep requesting
        do_reset();
        clear_obs();
        m0_valid = 1; m0_addr = 32'h0000_1000;
        m1_valid = 1; m1_addr = 32'h0000_2000;
        s_ready = 1; s_rdata = 32'h0BAD_F00D;
        for (int i = 0; i < 8; i++) step();
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        step();
        check("contend_sv_cycles", 32'(cnt_sv), 32'd4);
        check("contend_grants",    32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check($sformatf("contend_grant%0d", i), 32'(grant_log[i]), 32'(exp_seq[i]));

        // Write forwarding by m1
        clear_obs();
        m1_valid = 1; m1_addr = 32'h8000_1004; m1_wdata = 32'hA5A5_0000; m1_wstrb = 4'b0011;
        step();
        step();
        s_ready = 1;
        step();
        m1_valid = 0; s_ready = 0;
        step();
        check("write_addr",   cap_addr,          32'h8000_1004);
        check("write_wdata",  cap_wdata,         32'hA5A5_0000);
        check("write_wstrb",  32'(cap_wstrb),    32'(4'b0011));
        check("write_arb_zero", arb_or,          32'd0);
        check("write_m1_ready", 32'(cnt_r1),     32'd1);

        // Abort: m1 drops valid mid-BUSY
        clear_obs();
        m1_valid = 1; m1_addr = 32'h0000_3000; m1_wstrb = 4'h0;
        step(); step(); step();
        m1_valid = 0;
        step();
        step();
        check("abort_to_arb",   32'(obs_sv), 32'd0);
        check("abort_no_ready", 32'(cnt_r1), 32'd0);

        // Timeout on a hung address
        clear_obs();
        m0_valid = 1; m0_addr = 32'h4000_0000; m0_wstrb = 4'h0;
        step();                               // ARB
        seen = 0; bc = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (obs_sv) bc++;
            if (cnt_r0 != 0) seen = 1;
        end
        m0_valid = 0;
        step();
        check("timeout_busy_cycles", 32'(bc),     32'(TO));
        check("timeout_rdata",       cap_rd0,     ERR);
        check("timeout_pulses",      32'(cnt_to), 32'd1);
        check("timeout_err_count",   32'(obs_err), 32'd1);

        // s_ready on exactly the threshold cycle
        clear_obs();
        m0_valid = 1; m0_addr = 32'h4000_0000;
        step();
        for (int k = 0; k < TO - 1; k++) step();
        s_ready = 1; s_rdata = 32'hCAFE_0008;
        step();
        s_ready = 0; m0_valid = 0;
        step();
        check("edge_busy_cycles", 32'(cnt_sv),  32'(TO));
        check("edge_ready",       32'(cnt_r0),  32'd1);
        check("edge_rdata",       cap_rd0,      32'hCAFE_0008);
        check("edge_no_timeout",  32'(cnt_to),  32'd0);
        check("edge_err_count",   32'(obs_err), 32'd1);

        // Randomized traffic
        req[0] = 0; req[1] = 0;
        p = 50;
        for (int c = 0; c < 2400; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: p = 60;
                    1: p = 20;
                    default: p = 3;
                endcase
            end
            for (int i = 0; i < 2; i++) begin
                if (!req[i] && ($urandom_range(0, 3) == 0)) begin
                    req[i] = 1;
                    r_addr[i] = $urandom; r_wdata[i] = $urandom; r_wstrb[i] = 4'($urandom);
                end else if (req[i] && ($urandom_range(0, 63) == 0)) begin
                    req[i] = 0;
                end
            end
            m0_valid = req[0]; m0_addr = r_addr[0]; m0_wdata = r_wdata[0]; m0_wstrb = r_wstrb[0];
            m1_valid = req[1]; m1_addr = r_addr[1]; m1_wdata = r_wdata[1]; m1_wstrb = r_wstrb[1];
            s_ready = ($urandom_range(0, 99) < p);
            s_rdata = $urandom;
            step();
            for (int i = 0; i < 2; i++) if (exp_rdy[i]) req[i] = 0;
        end
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        for (int k = 0; k < 3; k++) step();

        // Reset in the middle of a transaction
        m0_valid = 1; m0_addr = 32'h0000_5000;
        step(); step();
        reset_n = 0;
        step();
        reset_n = 1; m0_valid = 0;
        clear_obs();
        step();
        check("rst_mid_s_valid", 32'(obs_sv),    32'd0);
        check("rst_mid_grant",   32'(obs_grant), 32'd0);
        check("rst_mid_err",     32'(obs_err),   32'd0);
        check("rst_mid_ready",   32'(cnt_r0),    32'd0);

        // 300 consecutive timeouts saturate err_count
        clear_obs();
        m0_valid = 1; m0_addr = 32'h4000_0000;
        for (int k = 0; k < 300 * (TO + 1); k++) step();
        m0_valid = 0;
        step();
        check("sat_timeouts",  32'(cnt_to),  32'd300);
        check("sat_err_count", 32'(obs_err), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
